mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared 8-to-1, 32-bit datapath mux.
- Eight requesters compete with valid/ready handshakes. The block picks one winner, drives the mux select, and captures the selected word into an output register.
- The registered word is presented downstream with its own valid/ready handshake.
- Used wherever several units share one 32-bit path, e.g. the writeback or LSU response bus.

Parameters:
DATA_W, 32, width of each requester word and of o_data
N_REQ, 8, requester count; fixed at 8 (3-bit select); any other value is illegal

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_req_valid  input  8  per-requester valid; bit k belongs to requester k
i_req_data  input  8*DATA_W  flattened requester words; requester k occupies bits [k*DATA_W +: DATA_W]
o_req_ready  output  8  one-hot or zero; bit k set = requester k is accepted this cycle
o_valid  output  1  output register holds an unconsumed word
o_data  output  DATA_W  registered selected word
o_grant_id  output  3  requester index of the word in o_data
i_ready  input  1  downstream accepts o_data when o_valid && i_ready
o_busy  output  1  equals o_valid; provided for status/debug

Behaviour:
- Reset (async, i_rst_n=0) forces:
  - state=IDLE
  - o_valid=0, o_data=0, o_grant_id=0
  - round-robin pointer ptr=0
  - o_req_ready=0 combinationally while reset is asserted
- Reset takes effect immediately, even with a word pending. The pending word is dropped and no ready pulses occur.
- States:
  - IDLE: output register empty.
  - FULL: output register holds a word.
  - o_valid = (state==FULL).
- Load condition: load = (state==IDLE) || (i_ready && state==FULL).
- Arbitration (combinational, each cycle):
  - Scan priority order ptr, ptr+1, ..., ptr+7 (mod 8).
  - The winner w is the first k with i_req_valid[k]=1.
  - If load && any valid: o_req_ready = one-hot(w); otherwise o_req_ready = 0.
  - o_req_ready may depend on i_req_valid. Requesters must not make valid depend on ready.
- Capture on a rising edge where load && any valid:
  - o_data <= word w
  - o_grant_id <= w
  - ptr <= (w+1) mod 8, wrapping 7 -> 0
  - state <= FULL
- Downstream handshake in FULL:
  - i_ready=1 and no valid request: state <= IDLE; o_data and o_grant_id hold their last values.
  - i_ready=1 and a valid request: back-to-back capture, state stays FULL. Throughput is one word per cycle.
  - i_ready=0: the register holds. o_data and o_grant_id are stable while o_valid=1, and o_req_ready=0.
- Timing:
  - Latency from request acceptance to o_valid is 1 cycle.
  - o_valid does not depend combinationally on i_ready.
- ptr changes only on capture. Idle cycles and stalls do not move it.
- Fairness: a continuously valid requester is granted within 8 captures.
- Simultaneous events:
  - A requester dropping valid in a cycle where it would win is simply not chosen. Arbitration uses the current cycle's valids only; there are no stored requests.
  - A requester granted at capture may re-request next cycle. It is then lowest priority unless it is the only one valid.
- Data of non-selected requesters is ignored. X on non-valid lanes must not propagate to o_data.

Test Plan:
- Reset: assert i_rst_n=0 mid-transfer with o_valid=1 -> o_valid=0, o_data=0, o_grant_id=0, o_req_ready=0 immediately. After release, the first grant goes to the lowest valid index ≥0.
- Single requester: i_req_valid=8'h08, data3=32'hDEADBEEF, i_ready=1 -> o_req_ready=8'h08 in cycle 0. Cycle 1: o_valid=1, o_data=32'hDEADBEEF, o_grant_id=3. Cycle 2: o_valid=0 once the request has dropped.
- All requesters, i_ready=1 held: i_req_valid=8'hFF continuous, data k = k -> o_grant_id sequence 0,1,...,7,0,1 on consecutive cycles, with o_valid held at 1.
- Backpressure: fill the register with requester 5 and hold i_ready=0 for 4 cycles with i_req_valid=8'h21 -> o_req_ready=0 and o_data/o_grant_id stable. When i_ready rises, the same-cycle ready goes to requester 0 (ptr=6 wraps to 0 before reaching 5).
- Wrap and fairness: i_req_valid=8'h81 continuous, starting from ptr=0 -> grants alternate 0,7,0,7. Pointer wrap 7->0 verified.
- Idle-to-valid race: o_valid=1 and i_ready=1 while requester 2 first raises valid -> back-to-back capture; o_grant_id=2 next cycle and o_valid never drops.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for eight valid/ready requesters sharing one 8:1 data mux.
// The winning word is captured into a single output register with its own handshake.
module mux8_rr_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_REQ  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_valid,
  output logic [DATA_W-1:0]       o_data,
  output logic [2:0]              o_grant_id,
  input  logic                    i_ready,
  output logic                    o_busy
);

  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   gid_q, gid_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic               load;
  logic               any_valid;
  logic               found;
  logic [SEL_W-1:0]   idx;
  logic [SEL_W-1:0]   win;
  logic [N_REQ-1:0]   win_oh;

  // Priority scan starting at ptr; the 3-bit add wraps 7 -> 0 naturally.
  always_comb begin
    any_valid = |i_req_valid;
    found     = 1'b0;
    idx       = '0;
    win       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = ptr_q + SEL_W'(i);
      if (!found && i_req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    win_oh = N_REQ'(1) << win;
  end

  assign load = (state_q == IDLE) || (i_ready && (state_q == FULL));

  // Gated by reset so no ready pulse can escape while reset is asserted.
  assign o_req_ready = (load && any_valid && i_rst_n) ? win_oh : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    if (load && any_valid) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (win == SEL_W'(k)) begin
          data_d = i_req_data[k*DATA_W +: DATA_W];
        end
      end
      gid_d   = win;
      ptr_d   = win + SEL_W'(1);
      state_d = FULL;
    end else if ((state_q == FULL) && i_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid    = (state_q == FULL);
  assign o_busy     = (state_q == FULL);
  assign o_data     = data_q;
  assign o_grant_id = gid_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: directed vector table, reset/corner sequences,
// then random traffic against a queue-free arithmetic reference model.
module tb_mux8_rr_arbiter;

  logic          i_clk;
  logic          i_rst_n;
  logic [7:0]    i_req_valid;
  logic [255:0]  i_req_data;
  logic [7:0]    o_req_ready;
  logic          o_valid;
  logic [31:0]   o_data;
  logic [2:0]    o_grant_id;
  logic          i_ready;
  logic          o_busy;

  mux8_rr_arbiter #(.DATA_W(32), .N_REQ(8)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_grant_id  (o_grant_id),
    .i_ready     (i_ready),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] lane [8];

  // Reference model state
  bit          m_full;
  int          m_ptr;
  int          m_gid;
  logic [31:0] m_data;

  typedef struct {
    logic [7:0] valid;
    logic       ready;
    logic [7:0] exp_rr;
    logic       exp_valid;
    logic [2:0] exp_gid;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] table_word(input int k);
    return (k == 3) ? 32'hDEADBEEF : 32'(k);
  endfunction

  task automatic drive_lanes();
    for (int k = 0; k < 8; k++) i_req_data[k*32 +: 32] = lane[k];
  endtask

  task automatic model_reset();
    m_full = 0; m_ptr = 0; m_gid = 0; m_data = 32'h0;
  endtask

  // One cycle against the model; entered and left at a falling edge.
  task automatic mstep(input logic [7:0] v, input logic r);
    int   w;
    bit   anyv;
    bit   ld;
    logic [7:0] exp_rr;
    w = -1;
    for (int i = 0; i < 8; i++) begin
      if (w < 0 && v[(m_ptr + i) % 8]) w = (m_ptr + i) % 8;
    end
    anyv   = (w >= 0);
    ld     = !m_full || r;
    exp_rr = (ld && anyv) ? 8'(1 << w) : 8'h00;
    i_req_valid = v;
    i_ready     = r;
    drive_lanes();
    #1;
    chk("rnd_req_ready", 32'(o_req_ready), 32'(exp_rr));
    chk("rnd_valid",     32'(o_valid),     32'(m_full));
    chk("rnd_busy",      32'(o_busy),      32'(m_full));
    chk("rnd_grant_id",  32'(o_grant_id),  32'(m_gid));
    chk("rnd_data",      o_data,           m_data);
    @(posedge i_clk);
    if (ld && anyv) begin
      m_data = lane[w];
      m_gid  = w;
      m_ptr  = (w + 1) % 8;
      m_full = 1;
    end else if (m_full && r) begin
      m_full = 0;
    end
    @(negedge i_clk);
  endtask

  initial begin
    // Directed sequence starting from reset: single, all-valid, backpressure, wrap, race.
    tbl[0]  = '{8'h08, 1'b1, 8'h08, 1'b0, 3'd0};
    tbl[1]  = '{8'h00, 1'b1, 8'h00, 1'b1, 3'd3};
    tbl[2]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0};
    tbl[3]  = '{8'hFF, 1'b1, 8'h10, 1'b0, 3'd0};
    tbl[4]  = '{8'hFF, 1'b1, 8'h20, 1'b1, 3'd4};
    tbl[5]  = '{8'hFF, 1'b1, 8'h40, 1'b1, 3'd5};
    tbl[6]  = '{8'hFF, 1'b1, 8'h80, 1'b1, 3'd6};
    tbl[7]  = '{8'hFF, 1'b1, 8'h01, 1'b1, 3'd7};
    tbl[8]  = '{8'hFF, 1'b1, 8'h02, 1'b1, 3'd0};
    tbl[9]  = '{8'h00, 1'b1, 8'h00, 1'b1, 3'd1};
    tbl[10] = '{8'h20, 1'b1, 8'h20, 1'b0, 3'd0};
    tbl[11] = '{8'h21, 1'b0, 8'h00, 1'b1, 3'd5};
    tbl[12] = '{8'h21, 1'b0, 8'h00, 1'b1, 3'd5};
    tbl[13] = '{8'h21, 1'b0, 8'h00, 1'b1, 3'd5};
    tbl[14] = '{8'h21, 1'b0, 8'h00, 1'b1, 3'd5};
    tbl[15] = '{8'h21, 1'b1, 8'h01, 1'b1, 3'd5};
    tbl[16] = '{8'h81, 1'b1, 8'h80, 1'b1, 3'd0};
    tbl[17] = '{8'h81, 1'b1, 8'h01, 1'b1, 3'd7};
    tbl[18] = '{8'h81, 1'b1, 8'h80, 1'b1, 3'd0};
    tbl[19] = '{8'h00, 1'b1, 8'h00, 1'b1, 3'd7};
    tbl[20] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0};
    tbl[21] = '{8'h01, 1'b0, 8'h01, 1'b0, 3'd0};
    tbl[22] = '{8'h04, 1'b1, 8'h04, 1'b1, 3'd0};
    tbl[23] = '{8'h00, 1'b0, 8'h00, 1'b1, 3'd2};
    tbl[24] = '{8'h00, 1'b1, 8'h00, 1'b1, 3'd2};
    tbl[25] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0};

    i_rst_n     = 1'b0;
    i_req_valid = 8'h00;
    i_ready     = 1'b0;
    for (int k = 0; k < 8; k++) lane[k] = table_word(k);
    drive_lanes();
    #1;
    chk("reset_valid",    32'(o_valid),     32'h0);
    chk("reset_data",     o_data,           32'h0);
    chk("reset_grant_id", 32'(o_grant_id),  32'h0);
    chk("reset_ready",    32'(o_req_ready), 32'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int n = 0; n < 26; n++) begin
      i_req_valid = tbl[n].valid;
      i_ready     = tbl[n].ready;
      #1;
      chk($sformatf("vec%0d_req_ready", n), 32'(o_req_ready), 32'(tbl[n].exp_rr));
      chk($sformatf("vec%0d_valid", n),     32'(o_valid),     32'(tbl[n].exp_valid));
      chk($sformatf("vec%0d_busy", n),      32'(o_busy),      32'(tbl[n].exp_valid));
      if (tbl[n].exp_valid) begin
        chk($sformatf("vec%0d_grant_id", n), 32'(o_grant_id), 32'(tbl[n].exp_gid));
        chk($sformatf("vec%0d_data", n),     o_data,          table_word(int'(tbl[n].exp_gid)));
      end
      @(posedge i_clk);
      @(negedge i_clk);
    end

    // Reset while a word is pending must drop it and suppress ready at once.
    i_req_valid = 8'h01;
    i_ready     = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    chk("pre_reset_full", 32'(o_valid), 32'h1);
    i_req_valid = 8'hFF;
    i_rst_n     = 1'b0;
    #1;
    chk("midrst_valid",    32'(o_valid),     32'h0);
    chk("midrst_data",     o_data,           32'h0);
    chk("midrst_grant_id", 32'(o_grant_id),  32'h0);
    chk("midrst_ready",    32'(o_req_ready), 32'h0);
    @(posedge i_clk);
    @(negedge i_clk);
    chk("midrst_ready_hold", 32'(o_req_ready), 32'h0);
    i_rst_n     = 1'b1;
    i_req_valid = 8'h06;
    i_ready     = 1'b1;
    #1;
    chk("post_reset_first_grant", 32'(o_req_ready), 32'h02);
    model_reset();
    mstep(8'h06, 1'b1);

    for (int c = 0; c < 3000; c++) begin
      logic [7:0] v;
      logic       r;
      for (int k = 0; k < 8; k++) lane[k] = $urandom;
      case ($urandom_range(0, 3))
        0:       v = 8'h00;
        1:       v = 8'(1 << $urandom_range(0, 7));
        2:       v = 8'($urandom) & 8'($urandom);
        default: v = 8'($urandom);
      endcase
      r = ($urandom_range(0, 3) != 0);
      mstep(v, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
